led_share_arbiter: RTL

Time-shares the board's single 3-bit active-low RGB LED among three pattern generators, such as the rainbow fader, a status blinker and a button-feedback flash. It sits between those generators and the top-level `led` pin. It grants ownership using a req/gnt handshake with round-robin fairness, bounded time slots and a forced dark gap between owners. Each requester drives its own color bus and the arbiter muxes the granted one onto the pin.

---
 rtl/led_share_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: time-shares one active-low RGB LED among three pattern
// generators using req/gnt, round-robin fairness, bounded slots and a dark gap
// between owners.
// Optional build macro: LED_ARB_PRIO0_EN gives requester 0 absolute priority.
module led_share_arbiter #(
  parameter int unsigned SLOT_TICKS = 1_200_000,
  parameter int unsigned GAP_TICKS  = 120_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] color0,
  input  logic [2:0] color1,
  input  logic [2:0] color2,
  output logic [2:0] gnt,
  output logic [2:0] led,
  output logic       busy
);

  localparam int unsigned SLOT_W = $clog2(SLOT_TICKS) + 1;
  localparam int unsigned GAP_W  = $clog2(GAP_TICKS) + 1;
  localparam logic [2:0]  LED_OFF = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          last_owner;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic [1:0]          next1_c;
  logic [1:0]          next2_c;
  logic [1:0]          winner_c;
  logic [2:0]          winner_oh_c;
  logic [2:0]          winner_color_c;
  logic [2:0]          owner_oh_c;
  logic [2:0]          owner_color_c;
  logic                owner_req_c;
  logic                others_req_c;
  logic                slot_end_c;
  logic                prio_preempt_c;

  // Round-robin search order after the last owner, plus owner/winner decode
  always_comb begin
    next1_c        = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
    next2_c        = (last_owner == 2'd0) ? 2'd2 : last_owner - 2'd1;
    winner_c       = last_owner;
    prio_preempt_c = 1'b0;
    if (req[next1_c]) begin
      winner_c = next1_c;
    end else if (req[next2_c]) begin
      winner_c = next2_c;
    end
`ifdef LED_ARB_PRIO0_EN
    if (req[0]) begin
      winner_c = 2'd0;
    end
    prio_preempt_c = req[0] && (last_owner != 2'd0);
`endif
    winner_oh_c  = 3'b001 << winner_c;
    owner_oh_c   = 3'b001 << last_owner;
    owner_req_c  = |(req & owner_oh_c);
    others_req_c = |(req & ~owner_oh_c);
    slot_end_c   = (slot_cnt == SLOT_W'(SLOT_TICKS - 1));
  end

  // Color mux for the arbitration winner and for the current owner
  always_comb begin
    winner_color_c = LED_OFF;
    owner_color_c  = LED_OFF;
    case (winner_c)
      2'd0:    winner_color_c = color0;
      2'd1:    winner_color_c = color1;
      2'd2:    winner_color_c = color2;
      default: winner_color_c = LED_OFF;
    endcase
    case (last_owner)
      2'd0:    owner_color_c = color0;
      2'd1:    owner_color_c = color1;
      2'd2:    owner_color_c = color2;
      default: owner_color_c = LED_OFF;
    endcase
  end

  // Ownership FSM with registered gnt/led/busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      led        <= LED_OFF;
      busy       <= 1'b0;
      last_owner <= 2'd2;
      slot_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= winner_oh_c;
            led        <= winner_color_c;
            last_owner <= winner_c;
            slot_cnt   <= '0;
            busy       <= 1'b1;
            state      <= GRANT;
          end else begin
            gnt  <= 3'b000;
            led  <= LED_OFF;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          led      <= owner_color_c;
          slot_cnt <= slot_cnt + SLOT_W'(1);
          // A drop takes precedence; expiry only yields to a waiting requester
          if (!owner_req_c || prio_preempt_c || (slot_end_c && others_req_c)) begin
            gnt     <= 3'b000;
            led     <= LED_OFF;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (slot_end_c) begin
            slot_cnt <= '0;
          end
        end
        GAP: begin
          gnt <= 3'b000;
          led <= LED_OFF;
          if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          gnt   <= 3'b000;
          led   <= LED_OFF;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
